ahb_bus_arbiter: RTL
====================

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have parameter TENURE, default 16, meaning the number of cycles of DMAC ownership after which a pending CPU request forces DMAC release.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Bus_Req  input  1  DMAC request for bus ownership.
REQ-005 SHALL have port Cpu_Req  input  1  CPU master request for bus ownership.
REQ-006 SHALL have port HReady  input  1  AHB transfer-complete / address-accept strobe.
REQ-007 SHALL have port HTrans  input  2  current owner's transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL have port HBurst  input  3  current owner's burst type (000 SINGLE, 001 INCR, 010/011 WRAP4/INCR4, 100/101 WRAP8/INCR8, 110/111 WRAP16/INCR16).
REQ-009 SHALL have port HMastLock  input  1  current owner requests a locked sequence.
REQ-010 SHALL have port Bus_Grant  output  1  DMAC owns the bus, registered.
REQ-011 SHALL have port Cpu_Grant  output  1  CPU owns the bus, registered.
REQ-012 SHALL have port HMaster  output  1  address-phase owner index (0 CPU, 1 DMAC), registered.

Function
REQ-013 SHALL implement a two-state FSM, CPU_OWN (Cpu_Grant=1, Bus_Grant=0) and DMA_OWN (Bus_Grant=1, Cpu_Grant=0); exactly one grant is high in every cycle, and the bus parks on the CPU when there are no requests.
REQ-014 SHALL keep a 4-bit remaining-beat counter rem, computed as rem_next:
- when HReady=1 and HTrans=NONSEQ: load 3/7/15 for 4/8/16-beat bursts, or 0 for SINGLE or INCR;
- when HReady=1, HTrans=SEQ and rem>0: rem-1;
- otherwise: hold rem.
REQ-015 SHALL define the arbitration point as AP = HReady & ~HMastLock & (rem_next==0); grants change only on the clock edge that ends an AP cycle.
REQ-016 SHALL keep a tenure counter that is cleared when DMA_OWN is entered, increments each cycle in DMA_OWN, and saturates at TENURE.
REQ-017 SHALL keep a cpu_done flag that is cleared when CPU_OWN is entered and set when HReady=1 and HTrans=NONSEQ while in CPU_OWN.
REQ-018 SHALL transition CPU_OWN->DMA_OWN at AP if Bus_Req=1 and (Cpu_Req=0 or cpu_done=1); otherwise it remains in CPU_OWN.
REQ-019 SHALL transition DMA_OWN->CPU_OWN at AP if Bus_Req=0, or if Cpu_Req=1 and tenure==TENURE; otherwise it remains in DMA_OWN.
REQ-020 SHALL hold the current grant when a request drops mid-burst or under lock, until the next AP.
REQ-021 SHALL update HMaster to the current grant owner (Bus_Grant) on each edge where HReady=1, and hold it otherwise.
REQ-022 SHALL give grant latency of one cycle: a request sampled high in an AP cycle with its conditions met yields the grant on the next cycle.
REQ-023 SHALL treat HTrans=BUSY as holding rem, and an IDLE issued while rem>0 as holding rem (the burst is not terminated early).
REQ-024 SHALL keep grants stable across any cycle with HReady=0, regardless of request changes.

Reset
REQ-025 SHALL, on rst=1 and asynchronously, enter CPU_OWN with Cpu_Grant=1, Bus_Grant=0, HMaster=0, rem=0, tenure=0 and cpu_done=0.
REQ-026 SHALL, when rst is asserted mid-burst or mid-lock, abandon the burst and return to the REQ-025 values.

Verification
REQ-027 SHALL cover: Bus_Req=1, Cpu_Req=0, HTrans=IDLE, HReady=1 -> Bus_Grant=1 next cycle, then HMaster=1 on the following HReady edge.
REQ-028 SHALL cover: DMAC issues INCR4 (NONSEQ+3 SEQ), Bus_Req drops after beat 1 -> Bus_Grant stays 1 until the edge ending the SEQ with rem=1, then Cpu_Grant=1.
REQ-029 SHALL cover: DMA_OWN with Bus_Req=1 held, Cpu_Req=1 from cycle 0, SINGLE transfers -> release to CPU at the first AP after 16 cycles; Bus_Grant returns only after CPU completes one NONSEQ.
REQ-030 SHALL cover: HMastLock=1 with HReady=1 and a competing request -> no grant change until HMastLock=0.
REQ-031 SHALL cover: HReady=0 for 5 cycles during a request toggle -> grants unchanged.
REQ-032 SHALL cover: rst pulsed during an INCR16 at beat 7 -> Cpu_Grant=1, Bus_Grant=0, HMaster=0 immediately; a fresh Bus_Req is granted at the first AP.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter (CPU / DMAC) with burst-aware arbitration points,
// lock handling and a DMAC tenure limit when the CPU is waiting.
module ahb_bus_arbiter #(
  parameter int unsigned TENURE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Bus_Req,
  input  logic       Cpu_Req,
  input  logic       HReady,
  input  logic [1:0] HTrans,
  input  logic [2:0] HBurst,
  input  logic       HMastLock,
  output logic       Bus_Grant,
  output logic       Cpu_Grant,
  output logic       HMaster
);

  localparam int unsigned TW = (TENURE < 1) ? 1 : $clog2(TENURE + 1);
  localparam logic [TW-1:0] TEN_MAX = TW'(TENURE);
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic {CPU_OWN, DMA_OWN} state_t;

  state_t        state, state_next;
  logic [3:0]    rem, rem_next;
  logic [TW-1:0] tenure;
  logic          cpu_done;
  logic          ap;

  // BUSY, IDLE and unaccepted beats all fall through to "hold"
  always_comb begin
    rem_next = rem;
    if (HReady && HTrans == TR_NONSEQ) begin
      unique case (HBurst)
        3'b010, 3'b011: rem_next = 4'd3;
        3'b100, 3'b101: rem_next = 4'd7;
        3'b110, 3'b111: rem_next = 4'd15;
        default:        rem_next = 4'd0;
      endcase
    end else if (HReady && HTrans == TR_SEQ && rem != '0) begin
      rem_next = rem - 4'd1;
    end
  end

  assign ap = HReady & ~HMastLock & (rem_next == '0);

  always_comb begin
    state_next = state;
    unique case (state)
      CPU_OWN: if (ap && Bus_Req && (!Cpu_Req || cpu_done)) state_next = DMA_OWN;
      DMA_OWN: if (ap && (!Bus_Req || (Cpu_Req && tenure == TEN_MAX))) state_next = CPU_OWN;
      default: state_next = CPU_OWN;
    endcase
  end

  always_comb begin
    Bus_Grant = (state == DMA_OWN);
    Cpu_Grant = (state == CPU_OWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CPU_OWN;
      rem   <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // Held at zero while the CPU owns the bus, so it starts from zero on DMA entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tenure <= '0;
    else if (state == CPU_OWN) tenure <= '0;
    else if (tenure != TEN_MAX) tenure <= tenure + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     cpu_done <= 1'b0;
    else if (state == DMA_OWN)                   cpu_done <= 1'b0;
    else if (HReady && HTrans == TR_NONSEQ)      cpu_done <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         HMaster <= 1'b0;
    else if (HReady) HMaster <= Bus_Grant;
  end

endmodule
